// File: rtl/uart_tx_framer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_framer_if
//   Bundles the handshake and serial-side signals of the UART transmit framer.
//   The master side (TX FIFO read logic plus baud generator) supplies the baud
//   tick, start request and data word. The slave side (the framer) returns the
//   busy flag, the end-of-frame pulse and the serial line.
//
//   Signals
//     i_s_tick        master -> slave  16x-oversampling baud tick
//     i_tx_start      master -> slave  request to send i_din
//     i_din[DBIT]     master -> slave  word to send
//     o_tx_busy       slave  -> master frame in progress
//     o_tx_done_tick  slave  -> master one-cycle end-of-frame pulse
//     o_tx            slave  -> master registered serial line (idles high)
// -----------------------------------------------------------------------------
interface uart_tx_framer_if #(
   parameter int DBIT = 8
);
   logic            i_s_tick;
   logic            i_tx_start;
   logic [DBIT-1:0] i_din;
   logic            o_tx_busy;
   logic            o_tx_done_tick;
   logic            o_tx;

   modport master (
      output i_s_tick,
      output i_tx_start,
      output i_din,
      input  o_tx_busy,
      input  o_tx_done_tick,
      input  o_tx
   );

   modport slave (
      input  i_s_tick,
      input  i_tx_start,
      input  i_din,
      output o_tx_busy,
      output o_tx_done_tick,
      output o_tx
   );
endinterface

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//   Serialises one parallel word into an asynchronous UART frame:
//   start bit, DBIT data bits LSB first, optional parity bit, stop bit(s).
//   Every bit lasts 16 baud ticks except the stop period, which lasts SB_TICK
//   ticks (16 = 1, 24 = 1.5, 32 = 2 stop bits).
//
//   Ports
//     i_clk     system clock, rising edge
//     i_reset   synchronous reset, active-high
//     bus       uart_tx_framer_if slave modport (tick, start, data in;
//               busy, done pulse, serial line out)
//
//   Parameters
//     DBIT        data bits per frame (5..9)
//     SB_TICK     ticks spent in the stop state
//     PARITY_EN   1 = append a parity bit after the data bits
//     PARITY_ODD  parity sense when enabled: 0 = even, 1 = odd
// -----------------------------------------------------------------------------
module uart_tx_framer #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   uart_tx_framer_if.slave bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   // Tick counter must reach 15 in the bit states and SB_TICK-1 in STOP.
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] S_LAST    = SW'(15);
   localparam logic [SW-1:0] SB_LAST   = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
   localparam logic          PAR_SENSE = (PARITY_ODD != 0);
   localparam logic [2:0]    AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

   logic [2:0]      state_reg, state_next;
   logic [SW-1:0]   s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            par_reg, par_next;
   logic            tx_reg, tx_next;
   logic            done_reg, done_next;

   // NOTE: every variable gets a default before the case so that paths which
   // do not assign it hold their value instead of inferring a latch.
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      par_next   = par_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.i_tx_start) begin
               b_next     = bus.i_din;
               par_next   = 1'b0;
               s_next     = '0;
               state_next = START;
            end
         end

         START: begin
            if (bus.i_s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = DATA;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end

         DATA: begin
            if (bus.i_s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next   = '0;
                  b_next   = b_reg >> 1;
                  par_next = par_reg ^ b_reg[0];
                  if (n_reg == N_LAST) begin
                     state_next = AFTER_DATA;
                  end else begin
                     n_next = n_reg + NW'(1);
                  end
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end

         PARITY: begin
            if (bus.i_s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next     = '0;
                  state_next = STOP;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end

         STOP: begin
            if (bus.i_s_tick) begin
               if (s_reg == SB_LAST) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end

         default: state_next = IDLE;
      endcase

      // The line is decoded from the next state and registered, so o_tx only
      // moves on the same edge as a state or bit boundary and never glitches.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = b_next[0];
         PARITY:  tx_next = par_next ^ PAR_SENSE;
         default: tx_next = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge i_clk) begin
      // NOTE: the reset clears every register, including the shift register,
      // because the frame contents must be deterministic after an abort.
      if (i_reset) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         par_reg   <= 1'b0;
         tx_reg    <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         par_reg   <= par_next;
         tx_reg    <= tx_next;
         done_reg  <= done_next;
      end
   end

   assign bus.o_tx           = tx_reg;
   assign bus.o_tx_busy      = (state_reg != IDLE);
   assign bus.o_tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//   Four framers share one stimulus stream:
//     dut0  8N1            dut1  8E1 (even parity)
//     dut2  8O1 (odd)      dut3  8N2 (SB_TICK = 32)
//   Each queued word is the expected content of one frame per instance. A
//   negedge monitor pops it when the line falls, checks the line against the
//   ideal waveform tick by tick, decodes the word at mid-bit and checks the
//   frame length in ticks when done_tick fires.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_tick;
   logic       start = 1'b0;
   logic [7:0] din = 8'h00;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   int tick_period = 1;
   bit tick_en     = 1'b1;
   int tick_cnt    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_framer_if #(.DBIT(8)) bus0 ();
   uart_tx_framer_if #(.DBIT(8)) bus1 ();
   uart_tx_framer_if #(.DBIT(8)) bus2 ();
   uart_tx_framer_if #(.DBIT(8)) bus3 ();

   assign bus0.i_s_tick = s_tick; assign bus0.i_tx_start = start; assign bus0.i_din = din;
   assign bus1.i_s_tick = s_tick; assign bus1.i_tx_start = start; assign bus1.i_din = din;
   assign bus2.i_s_tick = s_tick; assign bus2.i_tx_start = start; assign bus2.i_din = din;
   assign bus3.i_s_tick = s_tick; assign bus3.i_tx_start = start; assign bus3.i_din = din;

   uart_tx_framer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0))
      dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0.slave));
   uart_tx_framer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0))
      dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1.slave));
   uart_tx_framer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1))
      dut2 (.i_clk(clk), .i_reset(rst), .bus(bus2.slave));
   uart_tx_framer #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0))
      dut3 (.i_clk(clk), .i_reset(rst), .bus(bus3.slave));

   logic [3:0] tx_w, busy_w, done_w;
   assign tx_w   = {bus3.o_tx,           bus2.o_tx,           bus1.o_tx,           bus0.o_tx};
   assign busy_w = {bus3.o_tx_busy,      bus2.o_tx_busy,      bus1.o_tx_busy,      bus0.o_tx_busy};
   assign done_w = {bus3.o_tx_done_tick, bus2.o_tx_done_tick, bus1.o_tx_done_tick, bus0.o_tx_done_tick};

   // Baud tick: one cycle high every tick_period cycles (always high at 1).
   initial begin
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!tick_en) begin
            s_tick = 1'b0;
         end else begin
            tick_cnt = (tick_cnt + 1) % tick_period;
            s_tick   = (tick_cnt == 0);
         end
      end
   end

   // ---------------------------------------------------------------- model
   function automatic bit has_par(int k);
      return (k == 1) || (k == 2);
   endfunction

   function automatic int frame_len(int k);
      return 16 * (1 + 8 + (has_par(k) ? 1 : 0)) + ((k == 3) ? 32 : 16);
   endfunction

   // Ideal line level after t ticks of a frame carrying d on instance k.
   function automatic logic exp_line(int k, logic [7:0] d, int t);
      int   b   = t / 16;
      logic par = (^d) ^ (k == 2);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (has_par(k) && b == 9) return par;
      return 1'b1;
   endfunction

   // ---------------------------------------------------------- scoreboard
   typedef logic [7:0] byte_q_t [$];
   byte_q_t sb_q [4];

   bit         act      [4];
   int         t_cnt    [4];
   int         line_err [4];
   logic [7:0] cur      [4];
   logic [7:0] rx_data  [4];
   logic       rx_par   [4];
   int         fall_cyc [4];
   int         done_cyc [4];
   int         frames   [4];

   task automatic push_all(input logic [7:0] d);
      for (int k = 0; k < 4; k++) sb_q[k].push_back(d);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         act[k] = 1'b0; frames[k] = 0; rx_data[k] = 8'h00; rx_par[k] = 1'b0;
         fall_cyc[k] = 0; done_cyc[k] = 0; t_cnt[k] = 0; line_err[k] = 0; cur[k] = 8'h00;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (rst) begin
               act[k] = 1'b0;
            end else begin
               if (!act[k] && done_w[k] === 1'b1) begin
                  n_checks++; n_fails++;
                  $display("FAIL stray_done[%0d]: got done_tick=1 required 0 outside a frame", k);
               end
               if (!act[k] && tx_w[k] === 1'b0) begin
                  n_checks++;
                  if (sb_q[k].size() == 0) begin
                     n_fails++;
                     $display("FAIL unexpected_frame[%0d]: got start bit required idle line", k);
                     cur[k] = 8'h00;
                  end else begin
                     cur[k] = sb_q[k].pop_front();
                  end
                  act[k] = 1'b1; t_cnt[k] = 0; line_err[k] = 0;
                  rx_data[k] = 8'h00; rx_par[k] = 1'b0; fall_cyc[k] = cyc;
               end
               if (act[k]) begin
                  if (done_w[k] === 1'b1) begin
                     done_cyc[k] = cyc;
                     n_checks++;
                     if (t_cnt[k] != frame_len(k)) begin
                        n_fails++;
                        $display("FAIL frame_len[%0d]: got %0d ticks required %0d", k, t_cnt[k], frame_len(k));
                     end
                     n_checks++;
                     if (line_err[k] != 0) begin
                        n_fails++;
                        $display("FAIL line_shape[%0d] word %02h: got %0d bad cycles required 0", k, cur[k], line_err[k]);
                     end
                     n_checks++;
                     if (busy_w[k] !== 1'b0 || tx_w[k] !== 1'b1) begin
                        n_fails++;
                        $display("FAIL done_cycle[%0d]: got busy=%b tx=%b required busy=0 tx=1", k, busy_w[k], tx_w[k]);
                     end
                     act[k] = 1'b0;
                     frames[k]++;
                  end else begin
                     if (tx_w[k] !== exp_line(k, cur[k], t_cnt[k]) || busy_w[k] !== 1'b1) line_err[k]++;
                     for (int i = 1; i <= 8; i++)
                        if (t_cnt[k] == 16 * i + 8) rx_data[k][i-1] = tx_w[k];
                     if (has_par(k) && t_cnt[k] == 16 * 9 + 8) rx_par[k] = tx_w[k];
                     if (s_tick) t_cnt[k]++;
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic send(input logic [7:0] d);
      @(posedge clk); #1;
      din = d; start = 1'b1;
      push_all(d);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle_all(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy_w == 4'b0000 && !act[0] && !act[1] && !act[2] && !act[3] &&
             sb_q[0].size() == 0 && sb_q[1].size() == 0 &&
             sb_q[2].size() == 0 && sb_q[3].size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(input int k, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_w[k] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // --------------------------------------------------------------- tests
   task automatic test_reset();
      int bad = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_values[%0d]: got tx=%b busy=%b done=%b required 1/0/0",
                     k, tx_w[k], busy_w[k], done_w[k]);
         end
      end
      rst = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (tx_w !== 4'b1111 || busy_w !== 4'b0000 || done_w !== 4'b0000) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fails++;
         $display("FAIL idle_after_reset: got %0d bad cycles required 0", bad);
      end
   endtask

   task automatic test_basic_and_parity();
      bit ok;
      int f0;
      tick_period = 1;
      send(8'hA5);
      @(negedge clk);
      n_checks++;
      if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
         n_fails++;
         $display("FAIL start_latency: got tx=%b busy=%b required tx=0 busy=1", tx_w[0], busy_w[0]);
      end
      // A start pulse mid-frame with different data must be ignored.
      repeat (40) @(negedge clk);
      din = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0; din = 8'h00;
      wait_idle_all(600, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL basic_timeout: got busy required idle within 600 cycles"); end
      n_checks++;
      if (done_cyc[0] - fall_cyc[0] != 160) begin
         n_fails++;
         $display("FAIL done_timing_8n1: got %0d cycles required 160", done_cyc[0] - fall_cyc[0]);
      end
      n_checks++;
      if (done_cyc[1] - fall_cyc[1] != 176) begin
         n_fails++;
         $display("FAIL done_timing_8e1: got %0d cycles required 176", done_cyc[1] - fall_cyc[1]);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx_data[k] !== 8'hA5) begin
            n_fails++;
            $display("FAIL rx_a5[%0d]: got %02h required a5", k, rx_data[k]);
         end
      end
      n_checks++;
      if (rx_par[1] !== 1'b0) begin n_fails++; $display("FAIL parity_even: got %b required 0", rx_par[1]); end
      n_checks++;
      if (rx_par[2] !== 1'b1) begin n_fails++; $display("FAIL parity_odd: got %b required 1", rx_par[2]); end
      f0 = frames[0];
      repeat (20) @(negedge clk);
      n_checks++;
      if (frames[0] != f0 || busy_w !== 4'b0000) begin
         n_fails++;
         $display("FAIL ignored_start: got frames=%0d busy=%b required frames=%0d busy=0000", frames[0], busy_w, f0);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      tick_period = 4;
      @(posedge clk); #1;
      din = 8'h3C; start = 1'b1;
      push_all(8'h3C);
      wait_done(0, 1200, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL b2b_first_done: got no done_tick required one within 1200 cycles"); end
      // Next word presented in the done cycle; it is taken on the following edge.
      din = 8'hC3;
      push_all(8'hC3);
      @(negedge clk);
      n_checks++;
      if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
         n_fails++;
         $display("FAIL b2b_gap_8n1: got tx=%b busy=%b required tx=0 busy=1 one cycle after done", tx_w[0], busy_w[0]);
      end
      wait_done(1, 600, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL b2b_done_8e1: got no done_tick required one within 600 cycles"); end
      @(negedge clk);
      n_checks++;
      if (tx_w[3:1] !== 3'b000 || busy_w[3:1] !== 3'b111) begin
         n_fails++;
         $display("FAIL b2b_gap_others: got tx=%b busy=%b required tx=000 busy=111", tx_w[3:1], busy_w[3:1]);
      end
      start = 1'b0;
      wait_idle_all(2000, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL b2b_timeout: got busy required idle within 2000 cycles"); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx_data[k] !== 8'hC3) begin
            n_fails++;
            $display("FAIL b2b_second_word[%0d]: got %02h required c3", k, rx_data[k]);
         end
      end
      tick_period = 1;
   endtask

   task automatic test_tick_hold();
      bit         ok;
      logic [3:0] tx_snap, busy_snap;
      int         moved = 0;
      send(8'h81);
      repeat (20) @(negedge clk);
      tick_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tx_snap = tx_w; busy_snap = busy_w;
      repeat (30) begin
         @(negedge clk);
         if (tx_w !== tx_snap || busy_w !== busy_snap || done_w !== 4'b0000) moved++;
      end
      n_checks++;
      if (moved != 0 || busy_snap !== 4'b1111) begin
         n_fails++;
         $display("FAIL tick_hold: got %0d changed cycles busy=%b required 0 and 1111", moved, busy_snap);
      end
      tick_en = 1'b1;
      wait_idle_all(600, ok);
      n_checks++;
      if (!ok || rx_data[0] !== 8'h81) begin
         n_fails++;
         $display("FAIL tick_hold_word: got %02h idle=%b required 81 idle=1", rx_data[0], ok);
      end
   endtask

   task automatic test_stop_length();
      bit ok;
      tick_period = 1;
      send(8'h00);
      wait_idle_all(600, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL stop_timeout: got busy required idle within 600 cycles"); end
      n_checks++;
      if (done_cyc[3] - fall_cyc[3] != 176) begin
         n_fails++;
         $display("FAIL two_stop_bits: got %0d cycles required 176", done_cyc[3] - fall_cyc[3]);
      end
      n_checks++;
      if (rx_data[3] !== 8'h00) begin
         n_fails++;
         $display("FAIL rx_zero: got %02h required 00", rx_data[3]);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int bad = 0;
      tick_period = 1;
      send(8'h96);
      // Negedge 1 is tick 0 of the start bit; negedge 70 is tick 69, inside data bit 3.
      repeat (70) @(negedge clk);
      rst = 1'b1; start = 1'b1; din = 8'hFF;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_abort[%0d]: got tx=%b busy=%b done=%b required 1/0/0",
                     k, tx_w[k], busy_w[k], done_w[k]);
         end
      end
      rst = 1'b0; start = 1'b0;
      for (int k = 0; k < 4; k++) sb_q[k].delete();
      repeat (40) begin
         @(negedge clk);
         if (done_w !== 4'b0000 || busy_w !== 4'b0000 || tx_w !== 4'b1111) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fails++;
         $display("FAIL after_abort_quiet: got %0d bad cycles required 0", bad);
      end
      send(8'h5A);
      wait_idle_all(600, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL post_reset_timeout: got busy required idle within 600 cycles"); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx_data[k] !== 8'h5A) begin
            n_fails++;
            $display("FAIL post_reset_word[%0d]: got %02h required 5a", k, rx_data[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_and_parity();
      test_back_to_back();
      test_tick_hold();
      test_stop_length();
      test_reset_mid_frame();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
